board_line_read: RTL and testbench
==================================

BOARD_LINE_READ -- requirements
Module: board_line_read

Interface
REQ-001 Parameter: BURST_MAX, default 5, maximum points per burst (legal range 1..7).
REQ-002 clock  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 board  input  512  game board; point (x,y) at bits [x*32+y*2+1 : x*32+y*2].
REQ-005 req  input  1  read request; accepted only in a cycle where busy=0.
REQ-006 select  input  8  start point; [7:4] = x, [3:0] = y.
REQ-007 dir  input  2  step direction: 00 = +y, 01 = +x, 10 = +x+y, 11 = +x-y.
REQ-008 len  input  3  points to read; 0 means 1; values above BURST_MAX clamp to BURST_MAX.
REQ-009 busy  output  1  burst in progress.
REQ-010 valid  output  1  data/offboard/index/last are valid this cycle.
REQ-011 data  output  2  point information.
REQ-012 offboard  output  1  current point lies outside 0..15 on either axis.
REQ-013 index  output  3  position of the current point within the burst, starting at 0.
REQ-014 last  output  1  current point is the final point of the burst.

Function
REQ-015 FSM SHALL have two states: IDLE and READ.
REQ-016 IDLE with req=1: latch select, dir and effective len, then enter READ on the next edge.
REQ-017 IDLE with req=0: stay IDLE; valid=0.
REQ-018 Latency: the first valid point SHALL appear in the cycle after acceptance.
REQ-019 READ: one point per cycle, index incremented by 1 each cycle, with valid=1 on every cycle.
REQ-020 busy SHALL be 1 on every READ cycle, including the last-point cycle, and 0 in IDLE.
REQ-021 The req input SHALL be ignored while busy=1.
REQ-022 A new req SHALL be acceptable in the first cycle after last=1, giving a one-cycle gap between bursts.
REQ-023 The point for index i SHALL be the start point plus i times the direction vector.
REQ-024 Coordinate arithmetic SHALL use 5-bit signed values, with no wrap-around.
REQ-025 Off-board point: data=2'b00 and offboard=1; the burst SHALL continue for its full length.
REQ-026 data SHALL be a registered copy of board as sampled at the edge that produces it (see REQ-034 for the macro case).
REQ-027 last SHALL be 1 exactly when index equals effective len minus 1; the FSM enters IDLE on the next edge.
REQ-028 When valid=0, the outputs data, offboard, index and last SHALL all be 0.

Reset
REQ-029 While reset=0: FSM in IDLE; busy, valid, data, offboard, index and last all 0; latched request fields cleared.
REQ-030 Reset asserted mid-burst SHALL abandon the burst immediately, with no further valid output.
REQ-031 After reset is released, the first request SHALL be accepted on the first edge where req=1.

Configuration
REQ-032 The preprocessor macro BOARD_READ_SNAPSHOT_EN SHALL control board snapshotting.
REQ-033 Macro defined: the 512-bit board SHALL be registered at acceptance, and all points of the burst SHALL come from that snapshot.
REQ-034 Macro undefined: there SHALL be no snapshot register; each point SHALL be sampled from live board per REQ-026.
REQ-035 The interface and timing SHALL be identical in both builds.

Verification
REQ-036 Single point: board point (3,4)=2'b10; req with select=8'h34, len=1 -> one cycle later valid=1, data=10, index=0, last=1, offboard=0; busy=1 for one cycle.
REQ-037 Diagonal burst: points (5,5)..(9,9)=01; select=8'h55, dir=10, len=5 -> five consecutive valid cycles, data=01 each, index 0..4, last only on index 4.
REQ-038 Edge: select=8'hE0, dir=11, len=5 -> index0 (14,0) on-board; indices 1..4 offboard=1, data=00, no wrap to y=15.
REQ-039 Clamp and ignore: len=7 with BURST_MAX=5 -> exactly 5 points; req held high throughout -> next burst accepted one cycle after last, first valid two cycles after last.
REQ-040 Reset mid-burst: assert reset at index 2 -> all outputs 0 immediately, no index 3; release reset and send req -> normal burst.
REQ-041 Snapshot: change board point (0,2) from 00 to 11 during a +y burst from 8'h00 -> macro defined: data=00 at index 2; macro undefined: data=11.

Source files
------------

// File: rtl/board_line_read_if.sv
// Request/response bundle for board_line_read: request fields and the game
// board in, one board point per cycle out.
interface board_line_read_if;
    logic [511:0] board;
    logic         req;
    logic [7:0]   select;
    logic [1:0]   dir;
    logic [2:0]   len;
    logic         busy;
    logic         valid;
    logic [1:0]   data;
    logic         offboard;
    logic [2:0]   index;
    logic         last;

    modport master (
        output board, req, select, dir, len,
        input  busy, valid, data, offboard, index, last
    );

    modport slave (
        input  board, req, select, dir, len,
        output busy, valid, data, offboard, index, last
    );
endinterface

// File: rtl/board_line_read.sv
// Reads a straight line of up to BURST_MAX points from a 16x16 board of 2-bit cells.
// Define BOARD_READ_SNAPSHOT_EN to read the whole burst from a board copy taken at acceptance.
module board_line_read #(
    parameter int BURST_MAX = 5
) (
    input  logic              clock,
    input  logic              reset,
    board_line_read_if.slave  bus
);
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] READ = 1'b1;
    localparam logic [2:0] BMAX = 3'(BURST_MAX);

    logic [0:0]        state;
    logic [1:0]        dir_q;
    logic [2:0]        last_idx;
    logic signed [4:0] cur_x;
    logic signed [4:0] cur_y;
    logic              valid_q;
    logic [1:0]        data_q;
    logic              off_q;
    logic [2:0]        index_q;
    logic              last_q;
    logic [511:0]      src;

    logic signed [5:0] step_x;
    logic signed [5:0] step_y;
    logic signed [5:0] nx;
    logic signed [5:0] ny;
    logic              n_off;

    function automatic logic [2:0] eff_last(input logic [2:0] l);
        if (l == 3'd0) return 3'd0;
        if (l > BMAX)  return BMAX - 3'd1;
        return l - 3'd1;
    endfunction

    // Coordinates only move away from the board once off it, so clamping is harmless.
    function automatic logic signed [4:0] sat5(input logic signed [5:0] v);
        if (v > 6'sd15)  return 5'sd15;
        if (v < -6'sd16) return -5'sd16;
        return $signed(v[4:0]);
    endfunction

    function automatic logic on_board(input logic signed [5:0] v);
        return (v >= 6'sd0) && (v <= 6'sd15);
    endfunction

    function automatic logic [1:0] pick(input logic [511:0] b, input logic [3:0] x,
                                        input logic [3:0] y);
        return b[{x, y, 1'b0} +: 2];
    endfunction

    always_comb begin
        step_x = (dir_q == 2'b00) ? 6'sd0 : 6'sd1;
        step_y = 6'sd0;
        case (dir_q)
            2'b00:   step_y = 6'sd1;
            2'b01:   step_y = 6'sd0;
            2'b10:   step_y = 6'sd1;
            default: step_y = -6'sd1;
        endcase
        nx    = {cur_x[4], cur_x} + step_x;
        ny    = {cur_y[4], cur_y} + step_y;
        n_off = off_q | !on_board(nx) | !on_board(ny);
    end

`ifdef BOARD_READ_SNAPSHOT_EN
    logic [511:0] snap;

    always_ff @(posedge clock) begin
        if (state == IDLE && bus.req) snap <= bus.board;
    end

    assign src = snap;
`else
    assign src = bus.board;
`endif

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            dir_q    <= 2'b00;
            last_idx <= 3'd0;
            cur_x    <= 5'sd0;
            cur_y    <= 5'sd0;
            valid_q  <= 1'b0;
            data_q   <= 2'b00;
            off_q    <= 1'b0;
            index_q  <= 3'd0;
            last_q   <= 1'b0;
        end else if (state == IDLE) begin
            if (bus.req) begin
                // Point 0 is always on the board and comes straight from the live board.
                state    <= READ;
                dir_q    <= bus.dir;
                last_idx <= eff_last(bus.len);
                cur_x    <= $signed({1'b0, bus.select[7:4]});
                cur_y    <= $signed({1'b0, bus.select[3:0]});
                valid_q  <= 1'b1;
                data_q   <= pick(bus.board, bus.select[7:4], bus.select[3:0]);
                off_q    <= 1'b0;
                index_q  <= 3'd0;
                last_q   <= (eff_last(bus.len) == 3'd0);
            end
        end else begin
            if (last_q) begin
                state   <= IDLE;
                valid_q <= 1'b0;
                data_q  <= 2'b00;
                off_q   <= 1'b0;
                index_q <= 3'd0;
                last_q  <= 1'b0;
            end else begin
                cur_x   <= sat5(nx);
                cur_y   <= sat5(ny);
                off_q   <= n_off;
                data_q  <= n_off ? 2'b00 : pick(src, nx[3:0], ny[3:0]);
                index_q <= index_q + 3'd1;
                last_q  <= ((index_q + 3'd1) == last_idx);
            end
        end
    end

    assign bus.busy     = (state == READ);
    assign bus.valid    = valid_q;
    assign bus.data     = data_q;
    assign bus.offboard = off_q;
    assign bus.index    = index_q;
    assign bus.last     = last_q;
endmodule

// File: tb/tb_board_line_read.sv
// Scoreboard bench for board_line_read: stimulus queues expected points,
// a negedge monitor pops and compares every valid output.
module tb_board_line_read;
    logic clock = 1'b0;
    logic reset;

    board_line_read_if bus ();

    board_line_read #(.BURST_MAX(5)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    typedef logic [6:0] exp_t;  // {data, offboard, index, last}
    exp_t exp_q[$];
    exp_t mon_e;
    int   assertions = 0;
    int   failures   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        assertions++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    task automatic push(input logic [1:0] d, input logic o, input logic [2:0] i, input logic l);
        exp_q.push_back({d, o, i, l});
    endtask

    task automatic set_pt(input int x, input int y, input logic [1:0] v);
        bus.board[x*32 + y*2 +: 2] = v;
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while (bus.busy && n < 12) begin
            @(negedge clock);
            n++;
        end
        check("burst_end_busy", 32'(bus.busy), 32'd0);
        check("queue_drained", 32'(exp_q.size()), 32'd0);
    endtask

    // Called just after a negedge; returns once the burst has ended.
    task automatic run_burst(input logic [7:0] sel, input logic [1:0] d, input logic [2:0] l,
                             output int n);
        bus.select = sel;
        bus.dir    = d;
        bus.len    = l;
        bus.req    = 1'b1;
        @(negedge clock);
        bus.req = 1'b0;
        check("accept_busy", 32'(bus.busy), 32'd1);
        wait_idle(n);
    endtask

    always @(negedge clock) begin
        if (bus.valid) begin
            if (exp_q.size() == 0) begin
                assertions++;
                failures++;
                $display("FAIL unexpected_point: got %0h expected none",
                         {bus.data, bus.offboard, bus.index, bus.last});
            end else begin
                mon_e = exp_q.pop_front();
                check("point", 32'({bus.data, bus.offboard, bus.index, bus.last}), 32'(mon_e));
            end
        end else begin
            check("idle_zero", 32'({bus.data, bus.offboard, bus.index, bus.last}), 32'd0);
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        logic found;
        logic [10:0] pat;
        logic [1:0] snap_exp;

        reset      = 1'b0;
        bus.req    = 1'b0;
        bus.board  = '0;
        bus.select = 8'h00;
        bus.dir    = 2'b00;
        bus.len    = 3'd0;
        repeat (2) @(negedge clock);
        check("reset_outputs", 32'({bus.busy, bus.valid, bus.data, bus.offboard, bus.index, bus.last}),
              32'd0);
        reset = 1'b1;

        // Single point
        set_pt(3, 4, 2'b10);
        push(2'b10, 1'b0, 3'd0, 1'b1);
        run_burst(8'h34, 2'b00, 3'd1, n);
        check("single_busy_cycles", 32'(n), 32'd1);

        // Diagonal burst
        bus.board = '0;
        for (int i = 5; i <= 9; i++) set_pt(i, i, 2'b01);
        for (int i = 0; i < 5; i++) push(2'b01, 1'b0, 3'(i), i == 4);
        run_burst(8'h55, 2'b10, 3'd5, n);
        check("diag_busy_cycles", 32'(n), 32'd5);

        // Edge: leaves the board towards y=-1 without wrapping to y=15
        bus.board = '0;
        set_pt(14, 0, 2'b01);
        set_pt(15, 15, 2'b11);
        push(2'b01, 1'b0, 3'd0, 1'b0);
        for (int i = 1; i < 5; i++) push(2'b00, 1'b1, 3'(i), i == 4);
        run_burst(8'hE0, 2'b11, 3'd5, n);

        // len=0 reads one point
        push(2'b01, 1'b0, 3'd0, 1'b1);
        run_burst(8'hE0, 2'b01, 3'd0, n);
        check("len0_busy_cycles", 32'(n), 32'd1);

        // Clamp to 5 with req held high: back-to-back bursts with a one-cycle gap
        bus.board = '0;
        set_pt(3, 4, 2'b10);
        set_pt(7, 4, 2'b01);
        set_pt(8, 4, 2'b11);
        for (int b = 0; b < 2; b++) begin
            push(2'b10, 1'b0, 3'd0, 1'b0);
            push(2'b00, 1'b0, 3'd1, 1'b0);
            push(2'b00, 1'b0, 3'd2, 1'b0);
            push(2'b00, 1'b0, 3'd3, 1'b0);
            push(2'b01, 1'b0, 3'd4, 1'b1);
        end
        pat        = 11'b11111_0_11111;
        bus.select = 8'h34;
        bus.dir    = 2'b01;
        bus.len    = 3'd7;
        bus.req    = 1'b1;
        for (int i = 10; i >= 0; i--) begin
            @(negedge clock);
            check("clamp_busy", 32'(bus.busy), 32'(pat[i]));
            check("clamp_valid", 32'(bus.valid), 32'(pat[i]));
        end
        bus.req = 1'b0;
        @(negedge clock);
        check("clamp_end_busy", 32'(bus.busy), 32'd0);
        check("clamp_queue", 32'(exp_q.size()), 32'd0);

        // Reset mid-burst at index 2
        bus.board = '0;
        for (int i = 5; i <= 9; i++) set_pt(i, i, 2'b01);
        for (int i = 0; i < 5; i++) push(2'b01, 1'b0, 3'(i), i == 4);
        bus.select = 8'h55;
        bus.dir    = 2'b10;
        bus.len    = 3'd5;
        bus.req    = 1'b1;
        @(negedge clock);
        bus.req = 1'b0;
        found   = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (bus.valid && bus.index == 3'd2) begin
                found = 1'b1;
                break;
            end
            @(negedge clock);
        end
        check("reached_index2", 32'(found), 32'd1);
        #2 reset = 1'b0;
        #1;
        check("reset_async", 32'({bus.busy, bus.valid, bus.data, bus.offboard, bus.index, bus.last}),
              32'd0);
        exp_q.delete();
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        check("no_index3", 32'(bus.valid), 32'd0);
        for (int i = 0; i < 5; i++) push(2'b01, 1'b0, 3'(i), i == 4);
        run_burst(8'h55, 2'b10, 3'd5, n);
        check("post_reset_cycles", 32'(n), 32'd5);

        // Board changes under a +y burst
`ifdef BOARD_READ_SNAPSHOT_EN
        snap_exp = 2'b00;
`else
        snap_exp = 2'b11;
`endif
        bus.board = '0;
        push(2'b00, 1'b0, 3'd0, 1'b0);
        push(2'b00, 1'b0, 3'd1, 1'b0);
        push(snap_exp, 1'b0, 3'd2, 1'b1);
        bus.select = 8'h00;
        bus.dir    = 2'b00;
        bus.len    = 3'd3;
        bus.req    = 1'b1;
        @(negedge clock);
        bus.req = 1'b0;
        set_pt(0, 2, 2'b11);
        check("snap_accept_busy", 32'(bus.busy), 32'd1);
        wait_idle(n);

        repeat (2) @(negedge clock);
        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end
endmodule
